nyq_ctrl: RTL
=============

# nyq_ctrl

Sequencing controller for the Nyquist polyphase decimation filter. It gates coefficient loading, generates the polyphase index that addresses the coefficient memory for each MAC lane, and drives MAC clear/enable. It also drives the pipeline-register enable and the output-valid strobe, so the MAC/FF datapath produces exactly one output per DECIM accepted input samples. It sits between the block's parameter-write interface and the MAC array inside the NYQ block.

## Interface
- DECIM, 8, decimation factor = taps per MAC lane.
- NUM_MAC, 4, number of MAC lanes; coefficient base for lane k = Phase_DO + k*DECIM.
- CNT_WIDTH, 3, width of Phase_DO; equals clog2(DECIM).
- ADDR_WIDTH, 9, parameter memory address width.
- FCNT_WIDTH, 16, width of output frame counter.
- Clk_CI  in  1  clock, all state on rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- LoadFlag_DI  in  1  high while coefficients are being written.
- WrEn_SI  in  1  parameter write strobe; counted during LOAD.
- InValid_SI  in  1  new input sample present this cycle.
- Phase_DO  out  CNT_WIDTH  current polyphase index.
- MacEn_SO  out  1  MAC accumulate enable.
- MacClr_SO  out  1  MAC restart: acc <= product, not acc + product.
- RegEn_SO  out  1  enable for the lane pipeline FFs.
- Valid_DO  out  1  one-cycle pulse, filter output valid.
- Ready_DO  out  1  high in RUN.
- LoadErr_DO  out  1  sticky; last load had too few writes.
- FrameCnt_DO  out  FCNT_WIDTH  outputs produced since reset, wraps.

## Operation
- States: IDLE, LOAD, FLUSH, RUN. Reset enters IDLE.
- IDLE -> LOAD when LoadFlag_DI=1.
- LOAD:
  - Clear write counter LdCnt (ADDR_WIDTH+1 bits) on entry.
  - Increment LdCnt on each WrEn_SI; saturate at max.
  - On LoadFlag_DI=0: if LdCnt >= NUM_MAC*DECIM, go to FLUSH and clear LoadErr_DO. Otherwise go to IDLE and set LoadErr_DO.
- FLUSH: one cycle. Phase <= 0, pipeline strobes cleared. Go to RUN.
- RUN:
  - MacEn_SO = InValid_SI, combinational. MacClr_SO = InValid_SI & (Phase==0).
  - On each accepted sample, Phase <= (Phase==DECIM-1) ? 0 : Phase+1.
  - An accepted sample at Phase==DECIM-1 sets RegEn_SO in the next cycle.
- RegEn pipeline:
  - Valid_DO = RegEn_SO delayed one cycle.
  - FrameCnt_DO increments when Valid_DO=1 and wraps at 2^FCNT_WIDTH.
- RUN -> LOAD when LoadFlag_DI=1, at any phase. This aborts the partial frame:
  - Phase <= 0.
  - Pending RegEn_SO/Valid_DO pulses are cancelled.
  - InValid_SI is ignored from that cycle on.
- LoadFlag_DI has priority over InValid_SI in the same cycle; the sample is dropped.
- InValid_SI outside RUN: MacEn_SO=MacClr_SO=0 and Phase holds.
- Reset values: state IDLE, Phase_DO=0, RegEn_SO=0, Valid_DO=0, Ready_DO=0, LoadErr_DO=0, FrameCnt_DO=0, LdCnt=0.
- Asynchronous reset at any point forces all reset values immediately. No pulse completes after reset.

## Timing
- Phase_DO, RegEn_SO, Valid_DO, Ready_DO, LoadErr_DO and FrameCnt_DO are registered.
- MacEn_SO and MacClr_SO are combinational from InValid_SI and registered state.
- Latency:
  - Last sample of a frame accepted at cycle t -> RegEn_SO at t+1, Valid_DO at t+2.
  - FrameCnt_DO shows the updated value at t+3.
- Back-to-back frames are sustained at full rate with no bubble: MacClr_SO on the first sample of frame n+1 can coincide with RegEn_SO of frame n.
- LoadFlag_DI falling edge seen at cycle t -> FLUSH at t+1, Ready_DO=1 at t+2.

## Structure
- Shared package nyq_pkg holds:
  - state enum (IDLE, LOAD, FLUSH, RUN);
  - DECIM, NUM_MAC, CNT_WIDTH defaults;
  - COEFF_COUNT = NUM_MAC*DECIM.
- Sub-module nyq_phase_cnt: modulo-DECIM counter with enable and synchronous clear, outputs Phase and a wrap flag.
- FSM, load counter, strobe pipeline and frame counter live in nyq_ctrl.

## Test plan
- Reset, then InValid_SI=1 for 10 cycles with no load -> stays IDLE, all outputs 0, Phase_DO=0.
- LoadFlag high, 32 WrEn pulses, LoadFlag low -> FLUSH one cycle, Ready_DO=1 two cycles after the fall, LoadErr_DO=0.
- Load with only 20 writes -> LoadErr_DO=1, state IDLE, Ready_DO=0. A subsequent 32-write load clears LoadErr_DO.
- After a valid load, 16 consecutive InValid -> Phase_DO cycles 0..7, 0..7.
  - MacClr_SO on samples 1 and 9.
  - RegEn_SO one cycle after samples 8 and 16; Valid_DO one cycle after each RegEn_SO.
  - FrameCnt_DO=2.
- InValid every 3rd cycle for 8 samples -> Phase_DO advances only on valid samples; one RegEn_SO, one Valid_DO.
- Mid-operation cases:
  - LoadFlag rises after 5 samples -> Phase_DO=0, no RegEn_SO/Valid_DO; after reload, first sample asserts MacClr_SO.
  - Rst_RBI low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/nyq_pkg.sv
// nyq_pkg: shared defaults and state encoding for the Nyquist decimator controller
package nyq_pkg;
    localparam int DECIM       = 8;
    localparam int NUM_MAC     = 4;
    localparam int CNT_WIDTH   = $clog2(DECIM);
    localparam int ADDR_WIDTH  = 9;
    localparam int FCNT_WIDTH  = 16;
    localparam int COEFF_COUNT = NUM_MAC * DECIM;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
endpackage

// File: rtl/nyq_phase_cnt.sv
// nyq_phase_cnt: modulo-DECIM polyphase index counter with enable and synchronous clear
module nyq_phase_cnt #(
    parameter int DECIM     = nyq_pkg::DECIM,
    parameter int CNT_WIDTH = nyq_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] phase,
    output logic                 wrap
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DECIM - 1);

    assign wrap = en && phase == LAST;

    // clear wins over advance so an abort always restarts the frame at phase 0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) phase <= '0;
        else if (clr) phase <= '0;
        else if (en) phase <= wrap ? '0 : phase + 1'b1;
endmodule

// File: rtl/nyq_ctrl.sv
// nyq_ctrl: coefficient-load gating, polyphase sequencing and MAC/output strobes for the NYQ block
module nyq_ctrl #(
    parameter int DECIM      = nyq_pkg::DECIM,
    parameter int NUM_MAC    = nyq_pkg::NUM_MAC,
    parameter int CNT_WIDTH  = nyq_pkg::CNT_WIDTH,
    parameter int ADDR_WIDTH = nyq_pkg::ADDR_WIDTH,
    parameter int FCNT_WIDTH = nyq_pkg::FCNT_WIDTH
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  LoadFlag_DI,
    input  logic                  WrEn_SI,
    input  logic                  InValid_SI,
    output logic [CNT_WIDTH-1:0]  Phase_DO,
    output logic                  MacEn_SO,
    output logic                  MacClr_SO,
    output logic                  RegEn_SO,
    output logic                  Valid_DO,
    output logic                  Ready_DO,
    output logic                  LoadErr_DO,
    output logic [FCNT_WIDTH-1:0] FrameCnt_DO
);
    import nyq_pkg::*;

    localparam logic [ADDR_WIDTH:0] COEFF_CNT = (ADDR_WIDTH + 1)'(NUM_MAC * DECIM);

    state_t              state;
    logic [ADDR_WIDTH:0] ld_cnt;
    logic                run;
    logic                abort;
    logic                accept;
    logic                wrap;

    // a load request in RUN aborts the frame and drops any sample offered alongside it
    assign run       = state == RUN;
    assign abort     = run && LoadFlag_DI;
    assign accept    = run && InValid_SI && !LoadFlag_DI;
    assign MacEn_SO  = accept;
    assign MacClr_SO = accept && Phase_DO == '0;

    nyq_phase_cnt #(.DECIM(DECIM), .CNT_WIDTH(CNT_WIDTH)) u_phase (
        .clk   (Clk_CI),
        .rst_n (Rst_RBI),
        .en    (accept),
        .clr   (state == FLUSH || abort),
        .phase (Phase_DO),
        .wrap  (wrap)
    );

    // control FSM with load counter and the registered strobe pipeline
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state      <= IDLE;
            ld_cnt     <= '0;
            RegEn_SO   <= 1'b0;
            Valid_DO   <= 1'b0;
            Ready_DO   <= 1'b0;
            LoadErr_DO <= 1'b0;
        end else begin
            RegEn_SO <= wrap;
            Valid_DO <= RegEn_SO && !abort;
            case (state)
                IDLE: if (LoadFlag_DI) begin
                    state  <= LOAD;
                    ld_cnt <= '0;
                end
                LOAD: if (!LoadFlag_DI) begin
                    state      <= ld_cnt >= COEFF_CNT ? FLUSH : IDLE;
                    LoadErr_DO <= ld_cnt < COEFF_CNT;
                end else if (WrEn_SI && ld_cnt != '1) begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
                FLUSH: begin
                    state    <= RUN;
                    Ready_DO <= 1'b1;
                end
                RUN: if (LoadFlag_DI) begin
                    state    <= LOAD;
                    ld_cnt   <= '0;
                    Ready_DO <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // count every output strobe, wrapping naturally at the counter width
    always_ff @(posedge Clk_CI or negedge Rst_RBI)
        if (!Rst_RBI) FrameCnt_DO <= '0;
        else if (Valid_DO) FrameCnt_DO <= FrameCnt_DO + 1'b1;
endmodule
